// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO transmitter.
// PISO_PARITY_BIT_EN appends an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef PISO_PARITY_BIT_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int frame_len(input int width);
        return width + (PARITY_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_shift_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface piso_shift_if #(parameter int WIDTH = 4);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (output load_valid, din,
                    input  load_ready, sout, sout_valid, busy, done);
    modport slave  (input  load_valid, din,
                    output load_ready, sout, sout_valid, busy, done);
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module piso_bit_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          is_zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign count   = cnt;
    assign is_zero = (cnt == '0);
endmodule

// File: rtl/piso_shift.sv
// Parallel-in/serial-out transmitter: MSB-first, registered outputs, back-to-back reload.
// Define PISO_PARITY_BIT_EN to append an even-parity bit after din[0].
module piso_shift
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    piso_shift_if.slave  bus
);
    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = $clog2(FRAME_LEN);

    logic [0:0]       state;
    logic [WIDTH-2:0] sreg;
    logic             sout_q, sout_valid_q, done_q;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             last_bit, load_ready, accept, next_is_last, nxt_bit;

    // Counter tracks bits still to follow the one currently on sout.
    piso_bit_counter #(.CW(CW)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .value   (CW'(FRAME_LEN - 1)),
        .dec     ((state == ST_SHIFT) & ~cnt_zero),
        .count   (cnt),
        .is_zero (cnt_zero)
    );

    assign last_bit     = (state == ST_SHIFT) & cnt_zero;
    assign load_ready   = (state == ST_IDLE) | last_bit;
    assign accept       = bus.load_valid & load_ready;
    assign next_is_last = (cnt == CW'(1));

`ifdef PISO_PARITY_BIT_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^bus.din;
    end

    assign nxt_bit = next_is_last ? par_q : sreg[WIDTH-2];
`else
    assign nxt_bit = sreg[WIDTH-2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sreg         <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (accept) begin
            // MSB goes straight to the output register; sreg keeps the rest.
            state        <= ST_SHIFT;
            sreg         <= bus.din[WIDTH-2:0];
            sout_q       <= bus.din[WIDTH-1];
            sout_valid_q <= 1'b1;
            done_q       <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if (cnt_zero) begin
                state        <= ST_IDLE;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
                done_q       <= 1'b0;
            end else begin
                sreg   <= sreg << 1;
                sout_q <= nxt_bit;
                done_q <= next_is_last;
            end
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state == ST_SHIFT);
endmodule

// File: tb/tb_piso_shift.sv
// Directed bench for piso_shift: frame-queue reference model checked every cycle,
// plus literal expectations for the captured serial streams.
module tb_piso_shift;
    localparam int W = 4;
`ifdef PISO_PARITY_BIT_EN
    localparam int FL = W + 1;
    localparam logic [15:0] T1_EXP = 16'b10111;
    localparam logic [15:0] T2_EXP = 16'b1010001010;
    localparam logic [15:0] T3_EXP = 16'b0110011110;
`else
    localparam int FL = W;
    localparam logic [15:0] T1_EXP = 16'b1011;
    localparam logic [15:0] T2_EXP = 16'b10100101;
    localparam logic [15:0] T3_EXP = 16'b01101111;
`endif

    logic clk = 1'b0;
    logic rst_n;
    piso_shift_if #(.WIDTH(W)) bus ();

    piso_shift #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // 4-stage serial receiver: rx[0]=q0 ... rx[3]=out
    logic [3:0] rx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rx <= '0;
        else if (bus.sout_valid) rx <= {rx[2:0], bus.sout};
    end

    int nvec = 0;
    int nerr = 0;
    logic mq[$];           // bits still to appear on sout; mq[0] is the current one
    logic [15:0] cap;
    int ncap, ndone, nready_lo;

    task automatic chk(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_lit(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs();
        int n = mq.size();
        chk("sout",       bus.sout,       (n > 0) ? mq[0] : 1'b0);
        chk("sout_valid", bus.sout_valid, n > 0);
        chk("busy",       bus.busy,       n > 0);
        chk("done",       bus.done,       n == 1);
        chk("load_ready", bus.load_ready, n <= 1);
    endtask

    task automatic model_edge(input logic lv, input logic [W-1:0] d);
        logic rdy, dummy;
        rdy = (mq.size() <= 1);
        if (mq.size() > 0) dummy = mq.pop_front();
        if (lv && rdy) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
`ifdef PISO_PARITY_BIT_EN
            mq.push_back(^d);
`endif
        end
    endtask

    // Called at posedge+1: drive, check at negedge, advance model at the edge.
    task automatic cycle(input logic lv, input logic [W-1:0] d);
        bus.load_valid = lv;
        bus.din        = d;
        @(negedge clk);
        check_outputs();
        if (bus.sout_valid) begin cap = {cap[14:0], bus.sout}; ncap++; end
        if (bus.done) ndone++;
        if (!bus.load_ready) nready_lo++;
        @(posedge clk);
        model_edge(lv, d);
        #1;
    endtask

    task automatic clr_cap();
        cap = '0; ncap = 0; ndone = 0; nready_lo = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load_valid = 1'b0;
        bus.din = '0;
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        chk_lit("reset_ready", bus.load_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // single word from IDLE
        clr_cap();
        cycle(1'b1, 4'b1011);
        idle(FL + 1);
        chk_lit("t1_stream", cap, T1_EXP);
        chk_lit("t1_valid_cycles", ncap, FL);
        chk_lit("t1_done_pulses", ndone, 1);
        chk_lit("t1_ready_low", nready_lo, FL - 1);

        // back-to-back words, valid held
        clr_cap();
        cycle(1'b1, 4'hA);
        for (int i = 0; i < FL; i++) cycle(1'b1, 4'h5);
        idle(FL + 1);
        chk_lit("t2_stream", cap, T2_EXP);
        chk_lit("t2_valid_cycles", ncap, 2 * FL);
        chk_lit("t2_done_pulses", ndone, 2);

        // valid held with new din mid-word: only taken on last-bit cycle
        clr_cap();
        cycle(1'b1, 4'h6);
        for (int i = 0; i < FL; i++) cycle(1'b1, 4'hF);
        idle(FL + 1);
        chk_lit("t3_stream", cap, T3_EXP);
        chk_lit("t3_done_pulses", ndone, 2);

        // reset mid-word
        clr_cap();
        cycle(1'b1, 4'hF);
        cycle(1'b0, '0);
        @(negedge clk);
        check_outputs();
        #2 rst_n = 1'b0;
        mq.delete();
        #1;
        chk_lit("t4_sout", bus.sout, 0);
        chk_lit("t4_sout_valid", bus.sout_valid, 0);
        chk_lit("t4_busy", bus.busy, 0);
        chk_lit("t4_done", bus.done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(FL + 1);
        chk_lit("t4_ready_after", bus.load_ready, 1);
        chk_lit("t4_no_done", ndone, 0);

`ifndef PISO_PARITY_BIT_EN
        // loopback into the receiver chain
        clr_cap();
        cycle(1'b1, 4'b1101);
        idle(FL + 1);
        chk_lit("t6_rx_q0_to_out", {rx[0], rx[1], rx[2], rx[3]}, 4'b1011);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
